input_datapath: RTL and testbench

INPUT_DATAPATH -- requirements
Module: input_datapath

---
 rtl/input_datapath_pkg.sv | 20 ++
 rtl/input_datapath_if.sv | 25 ++
 rtl/input_datapath_vc_fifo.sv | 49 ++++
 rtl/input_datapath.sv | 70 +++++++
 tb/tb_input_datapath.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/input_datapath_pkg.sv
// Shared parameters and flit types for the router input datapath.
package input_datapath_pkg;

    localparam int N_VIRT_CHN   = 3;
    localparam int BUFFER_DEPTH = 4;
    localparam int FLIT_WIDTH   = 34;
    localparam int VC_W         = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'b00,
        FLIT_BODY = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_e;

    typedef struct packed {
        flit_type_e                 ftype;
        logic [FLIT_WIDTH-3:0]      payload;
    } flit_t;

endpackage

// File: rtl/input_datapath_if.sv
// Flit-in / flit-out handshake bundle between link, input datapath and router.
interface input_datapath_if #(
    parameter int N_VIRT_CHN = input_datapath_pkg::N_VIRT_CHN,
    parameter int FLIT_WIDTH = input_datapath_pkg::FLIT_WIDTH,
    parameter int VC_W       = input_datapath_pkg::VC_W
);
    logic                  fin_valid;
    logic [VC_W-1:0]       fin_vc_id;
    logic [FLIT_WIDTH-1:0] fin_data;
    logic [N_VIRT_CHN-1:0] fin_ready;
    logic                  fout_valid;
    logic [VC_W-1:0]       fout_vc_id;
    logic [FLIT_WIDTH-1:0] fout_data;
    logic                  fout_ready;

    modport master (
        output fin_valid, fin_vc_id, fin_data, fout_ready,
        input  fin_ready, fout_valid, fout_vc_id, fout_data
    );

    modport slave (
        input  fin_valid, fin_vc_id, fin_data, fout_ready,
        output fin_ready, fout_valid, fout_vc_id, fout_data
    );
endinterface

// File: rtl/input_datapath_vc_fifo.sv
// Single-clock circular flit buffer for one virtual channel; head is read combinationally.
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop_en, push_en;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_en  = pop && !empty;
    // A full buffer still takes a write when its head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/input_datapath.sv
// Per-VC input buffering with highest-VC-first arbitration and hold-while-stalled lock.
module input_datapath #(
    parameter int N_VIRT_CHN   = input_datapath_pkg::N_VIRT_CHN,
    parameter int BUFFER_DEPTH = input_datapath_pkg::BUFFER_DEPTH,
    parameter int FLIT_WIDTH   = input_datapath_pkg::FLIT_WIDTH
) (
    input  logic             clk,
    input  logic             arst_n,
    input_datapath_if.slave  io
);
    import input_datapath_pkg::*;

    localparam int VC_W = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

    logic [N_VIRT_CHN-1:0]                 full, empty, push, pop;
    logic [N_VIRT_CHN-1:0][FLIT_WIDTH-1:0] head;
    logic                                  locked, any_valid, fire;
    logic [VC_W-1:0]                       lock_vc, arb_vc, sel_vc;

    always_comb begin
        arb_vc = '0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            if (!empty[v]) arb_vc = VC_W'(v);
        end
    end

    // A stalled flit keeps the output; its head cannot change until it is popped.
    assign sel_vc    = locked ? lock_vc : arb_vc;
    assign any_valid = (|(~empty)) || locked;
    assign fire      = any_valid && io.fout_ready;

    genvar v;
    generate
        for (v = 0; v < N_VIRT_CHN; v++) begin : g_vc
            assign pop[v]  = fire && (sel_vc == VC_W'(v));
            assign push[v] = io.fin_valid && (io.fin_vc_id == VC_W'(v)) && (!full[v] || pop[v]);

            vc_fifo #(
                .DEPTH (BUFFER_DEPTH),
                .WIDTH (FLIT_WIDTH)
            ) u_fifo (
                .clk    (clk),
                .arst_n (arst_n),
                .push   (push[v]),
                .pop    (pop[v]),
                .din    (io.fin_data),
                .dout   (head[v]),
                .full   (full[v]),
                .empty  (empty[v])
            );
        end
    endgenerate

    assign io.fin_ready  = ~full;
    assign io.fout_valid = any_valid;
    assign io.fout_vc_id = any_valid ? sel_vc : '0;
    assign io.fout_data  = any_valid ? head[sel_vc] : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            locked  <= 1'b0;
            lock_vc <= '0;
        end else if (any_valid && !io.fout_ready) begin
            locked  <= 1'b1;
            lock_vc <= sel_vc;
        end else if (fire) begin
            locked  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_input_datapath.sv
// Directed bench: queue-per-VC reference model checked every cycle, plus literal scenario checks.
module tb_input_datapath;
    import input_datapath_pkg::*;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    input_datapath_if #(.N_VIRT_CHN(3), .FLIT_WIDTH(34), .VC_W(2)) bus ();

    input_datapath #(.N_VIRT_CHN(3), .BUFFER_DEPTH(4), .FLIT_WIDTH(34)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .io     (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    // Reference model: one queue per VC plus the stalled-output lock.
    logic [33:0] mq [0:2][$];
    bit          mlock;
    int          mlvc;
    int          ms;
    bit          mpop, macc;

    function automatic int m_sel();
        if (mlock) return mlvc;
        for (int v = 2; v >= 0; v--) if (mq[v].size() > 0) return v;
        return -1;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int v = 0; v < 3; v++) mq[v].delete();
            mlock = 0;
            mlvc  = 0;
        end else begin
            ms   = m_sel();
            mpop = (ms >= 0) && bus.fout_ready;
            macc = bus.fin_valid && (int'(bus.fin_vc_id) < 3) &&
                   ((mq[bus.fin_vc_id].size() < 4) || (mpop && ms == int'(bus.fin_vc_id)));
            if (ms >= 0 && !bus.fout_ready) begin
                mlock = 1;
                mlvc  = ms;
            end else if (mpop) begin
                mlock = 0;
            end
            if (mpop) void'(mq[ms].pop_front());
            if (macc) mq[bus.fin_vc_id].push_back(bus.fin_data);
        end
    end

    always @(negedge clk) begin
        int s;
        s = m_sel();
        chk("fout_valid", bus.fout_valid, (s >= 0) ? 1 : 0);
        chk("fout_vc_id", bus.fout_vc_id, (s >= 0) ? s : 0);
        chk("fout_data",  bus.fout_data,  (s >= 0) ? mq[s][0] : 34'h0);
        for (int v = 0; v < 3; v++)
            chk("fin_ready", bus.fin_ready[v], (mq[v].size() < 4) ? 1 : 0);
    end

    logic [33:0] out_log [$];
    always @(posedge clk) begin
        if (arst_n && bus.fout_valid && bus.fout_ready) out_log.push_back(bus.fout_data);
    end

    task automatic step(input logic v, input logic [1:0] vc, input logic [33:0] d, input logic r);
        bus.fin_valid  = v;
        bus.fin_vc_id  = vc;
        bus.fin_data   = d;
        bus.fout_ready = r;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 34'h0, r);
    endtask

    initial begin
        bus.fin_valid  = 0;
        bus.fin_vc_id  = 0;
        bus.fin_data   = 0;
        bus.fout_ready = 0;
        arst_n         = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", bus.fout_valid, 0);
        chk("rst_vc",    bus.fout_vc_id, 0);
        chk("rst_data",  bus.fout_data, 0);
        chk("rst_ready", bus.fin_ready, 3'b111);
        arst_n = 1;
        idle(1'b0, 2);

        // In-order streaming on VC0.
        out_log.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, mk(2'b01, 32'h100 + i), 1'b1);
        idle(1'b1, 3);
        chk("s035_count", out_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("s035_order", out_log[i], mk(2'b01, 32'h100 + i));

        // Overflow on VC1 is dropped.
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, mk(2'b01, 32'h200 + i), 1'b0);
        chk("s036_full", bus.fin_ready[1], 0);
        step(1'b1, 2'd1, 34'hAA, 1'b0);
        chk("s036_still_full", bus.fin_ready[1], 0);
        out_log.delete();
        idle(1'b1, 6);
        chk("s036_count", out_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("s036_order", out_log[i], mk(2'b01, 32'h200 + i));

        // Stalled VC0 holds the output against a later VC2 arrival.
        out_log.delete();
        step(1'b1, 2'd0, mk(2'b00, 32'hA0), 1'b0);
        step(1'b1, 2'd0, mk(2'b10, 32'hA1), 1'b0);
        step(1'b1, 2'd2, mk(2'b00, 32'hC0), 1'b0);
        idle(1'b0, 1);
        chk("s037_lock_vc",   bus.fout_vc_id, 0);
        chk("s037_lock_data", bus.fout_data, mk(2'b00, 32'hA0));
        idle(1'b1, 4);
        chk("s037_count", out_log.size(), 3);
        chk("s037_first",  out_log[0], mk(2'b00, 32'hA0));
        chk("s037_second", out_log[1], mk(2'b00, 32'hC0));
        chk("s037_third",  out_log[2], mk(2'b10, 32'hA1));

        // Full VC1 with concurrent push and pop keeps flowing.
        out_log.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, mk(2'b01, 32'h300 + i), 1'b0);
        for (int i = 4; i < 10; i++) begin
            step(1'b1, 2'd1, mk(2'b01, 32'h300 + i), 1'b1);
            chk("s038_ready_low", bus.fin_ready[1], 0);
        end
        idle(1'b1, 6);
        chk("s038_count", out_log.size(), 10);
        for (int i = 0; i < 10; i++) chk("s038_order", out_log[i], mk(2'b01, 32'h300 + i));

        // Pop of the last flit with a same-VC push leaves the new flit at the head.
        out_log.delete();
        step(1'b1, 2'd2, mk(2'b10, 32'hE0), 1'b0);
        step(1'b1, 2'd2, mk(2'b00, 32'hE1), 1'b1);
        chk("s025_valid", bus.fout_valid, 1);
        chk("s025_head",  bus.fout_data, mk(2'b00, 32'hE1));
        idle(1'b1, 2);
        chk("s025_count", out_log.size(), 2);

        // Asynchronous reset mid-packet.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, mk(2'b01, 32'h400 + i), 1'b0);
        bus.fin_valid = 0;
        #2;
        arst_n = 0;
        #1;
        chk("s039_valid",  bus.fout_valid, 0);
        chk("s039_ready",  bus.fin_ready, 3'b111);
        chk("s039_data",   bus.fout_data, 0);
        @(negedge clk);
        #1;
        arst_n = 1;
        out_log.delete();
        idle(1'b1, 3);
        chk("s039_after_valid", bus.fout_valid, 0);
        chk("s039_after_log",   out_log.size(), 0);

        // Out-of-range VC id is ignored.
        step(1'b1, 2'd3, mk(2'b00, 32'h55), 1'b1);
        idle(1'b1, 2);
        chk("s040_valid", bus.fout_valid, 0);
        chk("s040_ready", bus.fin_ready, 3'b111);
        chk("s040_log",   out_log.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
